seg_p2s_shifter: RTL and testbench

//  Serialises the 64-bit segment image (8 digits x 8 segment bits, digit 0 in bits [7:0])

---
 rtl/seg_p2s_if.sv | 13 +
 rtl/seg_p2s_shifter.sv | 91 +++++++++
 tb/tb_seg_p2s_shifter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seg_p2s_if.sv
// seg_p2s_if: parallel image, start request and serial-chain outputs of the segment shifter
interface seg_p2s_if #(parameter int WIDTH = 64);
  logic start;
  logic [WIDTH-1:0] P_Data;
  logic s_clk;
  logic s_data;
  logic s_clrn;
  logic s_pen;
  logic busy;
  logic done;
  modport master (output start, P_Data, input s_clk, s_data, s_clrn, s_pen, busy, done);
  modport slave (input start, P_Data, output s_clk, s_data, s_clrn, s_pen, busy, done);
endinterface

// File: rtl/seg_p2s_shifter.sv
// seg_p2s_shifter: shifts a WIDTH-bit segment image MSB first into a 74HC164-style chain, then latches it.
// Optional SEG_P2S_AUTO_REFRESH_EN: re-send automatically after reset or whenever P_Data changes.
module seg_p2s_shifter #(
  parameter int WIDTH = 64,
  parameter int DIV = 2
) (
  input logic clk,
  input logic rst,
  seg_p2s_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  localparam int PW = $clog2(DIV) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0] bcnt;
  logic [PW-1:0] pcnt;
  logic go;
  logic ph_end;
  logic last_bit;
  assign ph_end = pcnt == PW'(DIV - 1);
  assign last_bit = bcnt == BW'(WIDTH - 1);
`ifdef SEG_P2S_AUTO_REFRESH_EN
  logic [WIDTH-1:0] last_sent;
  logic dirty;
  assign go = bus.start | dirty | (bus.P_Data != last_sent);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_sent <= '0;
      dirty <= 1'b1;
    end else if (state == IDLE && go) begin
      last_sent <= bus.P_Data;
      dirty <= 1'b0;
    end
`else
  assign go = bus.start;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      bcnt <= '0;
      pcnt <= '0;
      bus.s_clk <= 1'b0;
      bus.s_data <= 1'b0;
      bus.s_clrn <= 1'b0;
      bus.s_pen <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.s_clrn <= 1'b1;
      bus.done <= 1'b0;
      case (state)
        IDLE:
          if (go) begin
            state <= SHIFT;
            shreg <= bus.P_Data;
            bus.s_data <= bus.P_Data[WIDTH-1];
            bus.busy <= 1'b1;
            bcnt <= '0;
            pcnt <= '0;
          end
        SHIFT:
          if (!ph_end) pcnt <= pcnt + 1'b1;
          else begin
            pcnt <= '0;
            bus.s_clk <= ~bus.s_clk;
            // falling edge of s_clk: the only moment s_data is allowed to move
            if (bus.s_clk) begin
              shreg <= shreg << 1;
              bus.s_data <= last_bit ? 1'b0 : shreg[WIDTH-2];
              bus.s_pen <= last_bit;
              state <= last_bit ? LATCH : SHIFT;
              bcnt <= last_bit ? bcnt : bcnt + 1'b1;
            end
          end
        LATCH:
          if (!ph_end) pcnt <= pcnt + 1'b1;
          else begin
            pcnt <= '0;
            bus.s_pen <= 1'b0;
            bus.done <= 1'b1;
            state <= DONE;
          end
        default: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_seg_p2s_shifter.sv
// tb_seg_p2s_shifter: table-driven and randomized checks of the serial stream and its cycle timing.
module tb_seg_p2s_shifter;
  localparam int W = 64;
  localparam int D = 2;
  localparam int EXP_FIRST = 1 + D;
  localparam int EXP_PEN_LO = 2 * W * D + 1;
  localparam int EXP_PEN_HI = (2 * W + 1) * D;
  localparam int EXP_DONE = (2 * W + 1) * D + 1;
  typedef struct {
    string nm;
    logic [W-1:0] v;
    logic [W-1:0] mid;
    bit poke;
    int first;
    int pen_lo;
    int pen_hi;
    int done_c;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  seg_p2s_if #(.WIDTH(W)) bus ();
  seg_p2s_shifter #(.WIDTH(W), .DIV(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  // call right after a negedge; sample k is taken after the k-th edge following acceptance
  task automatic txn(input vec_t t);
    int rises, first, pen_lo, pen_hi, pen_n, dones, done_c, unstable;
    logic [W-1:0] got;
    logic pclk, pdat;
    logic busy1;
    rises = 0; first = -1; pen_lo = -1; pen_hi = -1; pen_n = 0; dones = 0; done_c = -1;
    unstable = 0; got = '0; pclk = 0; pdat = 0; busy1 = 0;
    bus.P_Data = t.v;
    bus.start = 1;
    for (int k = 1; k <= EXP_DONE + 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 0;
        busy1 = bus.busy;
      end
      if (k == 40) bus.P_Data = t.mid;
      if (k == 50) bus.start = t.poke;
      if (k == 51) bus.start = 0;
      if (bus.s_clk && !pclk) begin
        rises++;
        got = {got[W-2:0], bus.s_data};
        if (first < 0) first = k;
      end
      if (bus.s_clk && pclk && bus.s_data !== pdat) unstable++;
      if (bus.s_pen) begin
        if (pen_lo < 0) pen_lo = k;
        pen_hi = k;
        pen_n++;
      end
      if (bus.done) begin
        dones++;
        done_c = k;
      end
      pclk = bus.s_clk;
      pdat = bus.s_data;
    end
    chk({t.nm, "_busy1"}, W'(busy1), W'(1));
    chk({t.nm, "_stream"}, got, t.v);
    chk({t.nm, "_rises"}, W'(rises), W'(W));
    chk({t.nm, "_first_rise"}, W'(first), W'(t.first));
    chk({t.nm, "_data_stable"}, W'(unstable), W'(0));
    chk({t.nm, "_pen_lo"}, W'(pen_lo), W'(t.pen_lo));
    chk({t.nm, "_pen_hi"}, W'(pen_hi), W'(t.pen_hi));
    chk({t.nm, "_pen_n"}, W'(pen_n), W'(D));
    chk({t.nm, "_dones"}, W'(dones), W'(1));
    chk({t.nm, "_done_cyc"}, W'(done_c), W'(t.done_c));
    chk({t.nm, "_idle_after"}, W'(bus.busy), W'(0));
  endtask
  task automatic count_dones(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) c++;
    end
  endtask
  initial begin
    vec_t tbl[8];
    int dq[3];
    int nd, idle, c;
    tbl[0] = '{"t2_corners", 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0,
               EXP_FIRST, EXP_PEN_LO, EXP_PEN_HI, EXP_DONE};
    tbl[1] = '{"t3_capture", 64'hC0F9_A4B0_9992_82F8, 64'h1234_5678_9ABC_DEF0, 1'b1,
               EXP_FIRST, EXP_PEN_LO, EXP_PEN_HI, EXP_DONE};
    tbl[2] = '{"t4_after", 64'hFFFF_0000_A5A5_5A5A, 64'h0, 1'b0,
               EXP_FIRST, EXP_PEN_LO, EXP_PEN_HI, EXP_DONE};
    for (int i = 3; i < 8; i++)
      tbl[i] = '{$sformatf("rnd%0d", i), {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), EXP_FIRST, EXP_PEN_LO, EXP_PEN_HI, EXP_DONE};
    bus.start = 0;
    bus.P_Data = 64'h0123_4567_89AB_CDEF;
    repeat (3) @(negedge clk);
    chk("rst_outputs", W'({bus.s_clk, bus.s_data, bus.s_clrn, bus.s_pen, bus.busy, bus.done}), W'(0));
    rst = 0;
    @(negedge clk);
    chk("rst_clrn_release", W'(bus.s_clrn), W'(1));
`ifdef SEG_P2S_AUTO_REFRESH_EN
    count_dones(EXP_DONE + 40, c);
    chk("auto_first", W'(c), W'(1));
    count_dones(EXP_DONE + 40, c);
    chk("auto_stable", W'(c), W'(0));
    bus.P_Data = bus.P_Data ^ 64'h0000_0100_0000_0000;
    count_dones(2 * EXP_DONE + 40, c);
    chk("auto_flip", W'(c), W'(1));
`else
    chk("idle_no_start", W'(bus.busy), W'(0));
    txn(tbl[0]);
    txn(tbl[1]);
    bus.P_Data = 64'hDEAD_BEEF_0000_FFFF;
    bus.start = 1;
    nd = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 0;
      if (bus.done) nd++;
    end
    #1 rst = 1;
    #1 chk("t4_rst_async", W'({bus.s_clk, bus.s_data, bus.s_clrn, bus.s_pen, bus.busy, bus.done}), W'(0));
    repeat (2) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    rst = 0;
    for (int k = 0; k < EXP_DONE; k++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("t4_no_done", W'(nd), W'(0));
    chk("t4_clrn", W'(bus.s_clrn), W'(1));
    for (int i = 2; i < 8; i++) txn(tbl[i]);
    bus.P_Data = {$urandom, $urandom};
    bus.start = 1;
    nd = 0;
    idle = 0;
    for (int k = 1; k <= 4 * EXP_DONE && nd < 3; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dq[nd] = k;
        nd++;
      end else if (nd == 1 && !bus.busy) idle++;
    end
    bus.start = 0;
    chk("t5_dones", W'(nd), W'(3));
    chk("t5_first_done", W'(dq[0]), W'(EXP_DONE));
    chk("t5_gap1", W'(dq[1] - dq[0]), W'(EXP_DONE + 1));
    chk("t5_gap2", W'(dq[2] - dq[1]), W'(EXP_DONE + 1));
    chk("t5_idle_cycles", W'(idle), W'(1));
    count_dones(EXP_DONE + 40, c);
    chk("t5_stop", W'(c), W'(0));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
